skin_pattern_gen: RTL
=====================

# skin_pattern_gen

Synthetic video source for the skin-detection pipeline. Produces a binary-mask pixel stream (0 background, 255 object) with frame-valid and line-valid framing, matching the input side of the centroid detector. Draws one filled rectangle, either at a programmed position or bouncing inside the active area. Used on-board and in simulation to drive the centroid path with known object geometry.

## Interface
- H_ACTIVE, 640: active pixels per line
- H_BLANK, 160: line-valid-low cycles per line
- V_ACTIVE, 480: active lines per frame
- V_BLANK, 45: frame-valid-low line periods per frame
- iClk  in  1  clock; single clock domain
- iRst  in  1  synchronous, active-high reset
- iEnable  in  1  run; a low level stops generation at the next frame boundary
- iRectX, iRectY  in  12 each  rectangle top-left corner (column, line)
- iRectW, iRectH  in  12 each  rectangle width and height
- iBounce  in  1  1 selects automatic bounce motion; 0 selects fixed position from iRectX/iRectY
- iStepX, iStepY  in  12 each  bounce step per frame
- oPixel  out  8  0 or 255
- oLineValid  out  1  line valid
- oFrameValid  out  1  frame valid
- oFrameStart  out  1  pulse, first cycle of oFrameValid
- oFrameDone  out  1  pulse, first cycle after oFrameValid falls
- oFrameCount  out  16  completed frames, wraps

## Operation
- Counters: rHCnt runs 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_BLANK). rVCnt runs 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_BLANK) and increments when rHCnt wraps.
- Frame valid = rVCnt < V_ACTIVE. Line valid = frame valid && rHCnt < H_ACTIVE. Each line therefore starts with line valid high, and frame valid drops after the last line's blank.
- Pixel = 255 iff line valid && PosX ≤ rHCnt < PosX+W && PosY ≤ rVCnt < PosY+H. Otherwise 0, including during blanking.
- Comparisons use 13-bit sums, with no wrap. The rectangle is clipped to the active area. W=0 or H=0 gives no object pixels.
- Frame boundary is counters at (0,0). At each frame boundary:
  - If iEnable=0: the counters hold at (0,0) and all outputs stay 0 (idle).
  - If iEnable=1: W and H are latched from iRectW/iRectH, and PosX/PosY are updated as below. Inputs are ignored mid-frame, so there is no tearing.
- Fixed mode (iBounce=0): PosX ← iRectX, PosY ← iRectY.
- Bounce mode (iBounce=1), X axis; the Y axis is identical using V_ACTIVE, H and iStepY:
  - Direction + and PosX+W+StepX > H_ACTIVE: flip direction, PosX unchanged.
  - Direction − and PosX < StepX: flip direction, PosX unchanged.
  - Otherwise PosX ← PosX ± StepX.
  - Bounce starts from the current position. Directions reset to +,+.
- oFrameCount increments together with the oFrameDone pulse.
- A mid-frame reset aborts the frame: all outputs go to 0 on the next cycle and no oFrameDone is issued.

## Timing
- Reset values: all outputs 0, counters 0, PosX/PosY 0, W/H 0, directions +.
- All outputs are registered. Outputs at cycle n+1 are a function of counter/state at cycle n (latency 1).
- The first edge with iRst=0 and iEnable=1 latches the frame-boundary values. The outputs for (0,0), i.e. oFrameValid=1, oLineValid=1, oFrameStart=1, appear one cycle later.
- oFrameValid is high for V_ACTIVE·H_TOTAL cycles per frame. oLineValid is high for H_ACTIVE consecutive cycles per line.
- The frame period is H_TOTAL·V_TOTAL cycles when continuously enabled. There is no gap between frames.
- iEnable dropping mid-frame lets the frame complete, including vertical blank. The block then idles.
- oFrameStart and oFrameDone are never high in the same cycle, and each is exactly 1 cycle wide.

## Test plan
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=6, V_BLANK=2, giving a 96-cycle frame.
- Reset then enable, fixed mode with X=2, Y=1, W=3, H=2:
  - oFrameValid high 72 cycles, low 24; oLineValid high 6×8 cycles per frame.
  - Exactly 6 cycles of oPixel=255, at lines 1–2, columns 2–4.
  - oFrameStart at first oFrameValid cycle; oFrameDone 72 cycles later.
  - oFrameCount=1 after the first frame.
- Clipping: X=6, Y=5, W=4, H=4 → 2 pixels of 255 per frame (line 5, columns 6–7).
- Change iRectX mid-frame from 2 to 5 → current frame still uses X=2; next frame uses X=5.
- Bounce X with W=3, StepX=2, X=0, StepY=0; one fixed frame, then iBounce=1 → subsequent frame PosX sequence 2,4,4,2,0,0,2.
- Drop iEnable at cycle 30 of a frame → frame completes (96 cycles total), then all outputs stay 0. Re-enable → oFrameStart 1 cycle after the enable edge.
- Assert iRst at cycle 40 → all outputs 0 next cycle, no oFrameDone, oFrameCount=0.

Source files
------------

// File: rtl/skin_pattern_gen.sv
// Synthetic binary-mask video source: one filled rectangle, fixed or bouncing,
// framed with frame-valid / line-valid exactly like the centroid detector input.
module skin_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic [11:0] iRectX,
    input  logic [11:0] iRectY,
    input  logic [11:0] iRectW,
    input  logic [11:0] iRectH,
    input  logic        iBounce,
    input  logic [11:0] iStepX,
    input  logic [11:0] iStepY,
    output logic [7:0]  oPixel,
    output logic        oLineValid,
    output logic        oFrameValid,
    output logic        oFrameStart,
    output logic        oFrameDone,
    output logic [15:0] oFrameCount
);

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_BLANK - 1);

    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [11:0] rect_w_q, rect_w_d, rect_h_q, rect_h_d;
    logic        dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
    logic [7:0]  pixel_q, pixel_d;
    logic        line_valid_q, line_valid_d, frame_valid_q, frame_valid_d;
    logic        frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        boundary, start, active, in_x, in_y;
    logic [12:0] bounce_x, bounce_y;

    // Returns {new_direction_is_negative, new_position} for one axis.
    function automatic logic [12:0] bounce_axis(input logic [11:0] pos, input logic [11:0] size,
                                                input logic [11:0] step, input logic [11:0] limit,
                                                input logic neg);
        logic [13:0] far_edge;
        logic [12:0] res;
        far_edge = {2'b00, pos} + {2'b00, size} + {2'b00, step};
        if (!neg) res = (far_edge > {2'b00, limit}) ? {1'b1, pos} : {1'b0, pos + step};
        else      res = (pos < step) ? {1'b0, pos} : {1'b1, pos - step};
        return res;
    endfunction

    // Counters parked at (0,0) are the frame boundary; they only leave it when enabled.
    always_comb begin
        boundary = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        start    = boundary && iEnable;
        active   = !boundary || iEnable;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        if (active) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 12'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    always_comb begin
        bounce_x    = bounce_axis(pos_x_q, iRectW, iStepX, H_ACT, dir_x_neg_q);
        bounce_y    = bounce_axis(pos_y_q, iRectH, iStepY, V_ACT, dir_y_neg_q);
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        rect_w_d    = rect_w_q;
        rect_h_d    = rect_h_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;
        if (start) begin
            rect_w_d = iRectW;
            rect_h_d = iRectH;
            if (iBounce) begin
                {dir_x_neg_d, pos_x_d} = bounce_x;
                {dir_y_neg_d, pos_y_d} = bounce_y;
            end else begin
                pos_x_d = iRectX;
                pos_y_d = iRectY;
            end
        end
    end

    // Geometry uses the _d values so the (0,0) pixel already sees the newly latched frame.
    always_comb begin
        in_x = ({1'b0, h_cnt_q} >= {1'b0, pos_x_d}) &&
               ({1'b0, h_cnt_q} <  ({1'b0, pos_x_d} + {1'b0, rect_w_d}));
        in_y = ({1'b0, v_cnt_q} >= {1'b0, pos_y_d}) &&
               ({1'b0, v_cnt_q} <  ({1'b0, pos_y_d} + {1'b0, rect_h_d}));
        frame_valid_d = active && (v_cnt_q < V_ACT);
        line_valid_d  = frame_valid_d && (h_cnt_q < H_ACT);
        pixel_d       = (line_valid_d && in_x && in_y) ? 8'hFF : 8'h00;
        frame_start_d = start;
        frame_done_d  = (h_cnt_q == 12'd0) && (v_cnt_q == V_ACT);
        frame_count_d = frame_count_q + {15'd0, frame_done_d};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            rect_w_q      <= '0;
            rect_h_q      <= '0;
            dir_x_neg_q   <= 1'b0;
            dir_y_neg_q   <= 1'b0;
            pixel_q       <= '0;
            line_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            rect_w_q      <= rect_w_d;
            rect_h_q      <= rect_h_d;
            dir_x_neg_q   <= dir_x_neg_d;
            dir_y_neg_q   <= dir_y_neg_d;
            pixel_q       <= pixel_d;
            line_valid_q  <= line_valid_d;
            frame_valid_q <= frame_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign oPixel      = pixel_q;
    assign oLineValid  = line_valid_q;
    assign oFrameValid = frame_valid_q;
    assign oFrameStart = frame_start_q;
    assign oFrameDone  = frame_done_q;
    assign oFrameCount = frame_count_q;

endmodule
